// File: rtl/app_display_arbiter_pkg.sv
// Shared state encodings, idle drive levels and sizing helpers for the display arbiter.
package app_display_arbiter_pkg;

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_ENTER = 2'd1,
    S_RUN   = 2'd2,
    S_EXIT  = 2'd3
  } state_t;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Frame counter width; never zero so the register stays legal when blanking is disabled.
  function automatic int cnt_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/app_display_arbiter_frame_blank_timer.sv
// Frame blank timer: counts frame_begin pulses during a blanking interval and flags the last one.
module app_display_arbiter_frame_blank_timer
  import app_display_arbiter_pkg::*;
#(
  parameter int BLANK_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic frame_begin,
  output logic done
);

  localparam int CNT_W = cnt_width(BLANK_FRAMES);

  generate
    if (BLANK_FRAMES == 0) begin : g_none
      // No blanking: the interval ends on its first cycle.
      assign done = 1'b1;
    end else begin : g_cnt
      localparam logic [CNT_W-1:0] LAST = CNT_W'(BLANK_FRAMES - 1);
      localparam logic [CNT_W-1:0] MAX  = CNT_W'(BLANK_FRAMES);

      logic [CNT_W-1:0] count;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count <= '0;
        end else if (frame_begin && (count != MAX)) begin
          count <= count + CNT_W'(1);
        end
      end

      // Fires combinationally on the final pulse so the FSM moves on that same edge.
      assign done = frame_begin && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/app_display_arbiter.sv
// Display arbiter: menu/app selection FSM with frame-synchronised blanking and a registered output mux.
module app_display_arbiter
  import app_display_arbiter_pkg::*;
#(
  parameter int          N_APPS       = 4,
  parameter int          IDX_W        = 4,
  parameter int          BLANK_FRAMES = 8,
  parameter logic [15:0] BLANK_COLOUR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_begin,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_select,
  input  logic                  force_exit,
  input  logic [N_APPS-1:0]     app_ended,
  input  logic [15:0]           menu_oled,
  input  logic [16*N_APPS-1:0]  app_oled,
  input  logic [4*N_APPS-1:0]   app_an,
  input  logic [8*N_APPS-1:0]   app_seg,
  output logic [15:0]           oled_data,
  output logic [3:0]            an,
  output logic [7:0]            seg,
  output logic [IDX_W-1:0]      cursor,
  output logic [IDX_W-1:0]      active_app,
  output logic [N_APPS-1:0]     app_enable,
  output logic                  in_menu
);

  localparam int               SLOTS    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_APPS - 1);

  state_t state;
  logic   blank_clear;
  logic   blank_done;
  logic   run_end;

  // Per-app slices padded to the full index range so any active_app value selects cleanly.
  logic [15:0]      oled_slot [SLOTS];
  logic [3:0]       an_slot   [SLOTS];
  logic [7:0]       seg_slot  [SLOTS];
  logic [SLOTS-1:0] ended_slot;

  generate
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      if (k < N_APPS) begin : g_app
        assign oled_slot[k]  = app_oled[16*k +: 16];
        assign an_slot[k]    = app_an[4*k +: 4];
        assign seg_slot[k]   = app_seg[8*k +: 8];
        assign ended_slot[k] = app_ended[k];
      end else begin : g_pad
        assign oled_slot[k]  = BLANK_COLOUR;
        assign an_slot[k]    = AN_OFF;
        assign seg_slot[k]   = SEG_OFF;
        assign ended_slot[k] = 1'b0;
      end
    end
  endgenerate

  // Blank states are only ever entered from S_MENU or S_RUN, so clearing there resets every interval.
  assign blank_clear = (state == S_MENU) || (state == S_RUN);
  assign run_end     = ended_slot[active_app] || force_exit;

  app_display_arbiter_frame_blank_timer #(
    .BLANK_FRAMES (BLANK_FRAMES)
  ) u_blank_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (blank_clear),
    .frame_begin (frame_begin),
    .done        (blank_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_MENU;
      cursor     <= '0;
      active_app <= '0;
      app_enable <= '0;
      in_menu    <= 1'b1;
    end else begin
      case (state)
        S_MENU: begin
          if (btn_select) begin
            active_app <= cursor;
            in_menu    <= 1'b0;
            state      <= S_ENTER;
          end else if (btn_up && !btn_down) begin
            cursor <= (cursor == '0) ? LAST_IDX : cursor - IDX_W'(1);
          end else if (btn_down && !btn_up) begin
            cursor <= (cursor == LAST_IDX) ? '0 : cursor + IDX_W'(1);
          end
        end
        S_ENTER: begin
          if (blank_done) begin
            app_enable <= N_APPS'(1) << active_app;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (run_end) begin
            app_enable <= '0;
            state      <= S_EXIT;
          end
        end
        S_EXIT: begin
          if (blank_done) begin
            cursor  <= active_app;
            in_menu <= 1'b1;
            state   <= S_MENU;
          end
        end
        default: state <= S_MENU;
      endcase
    end
  end

  // Output mux follows the registered state, giving one cycle of latency from any source.
  always_ff @(posedge clk) begin
    if (reset) begin
      oled_data <= BLANK_COLOUR;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      case (state)
        S_MENU: begin
          oled_data <= menu_oled;
          an        <= AN_OFF;
          seg       <= SEG_OFF;
        end
        S_RUN: begin
          oled_data <= oled_slot[active_app];
          an        <= an_slot[active_app];
          seg       <= seg_slot[active_app];
        end
        default: begin
          oled_data <= BLANK_COLOUR;
          an        <= AN_OFF;
          seg       <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_app_display_arbiter.sv
// Directed scoreboard bench for app_display_arbiter with N_APPS=4, BLANK_FRAMES=2.
module tb_app_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin, btn_up, btn_down, btn_select, force_exit;
  logic [3:0]  app_ended;
  logic [15:0] menu_oled;
  logic [63:0] app_oled;
  logic [15:0] app_an;
  logic [31:0] app_seg;
  logic [15:0] oled_data;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  cursor;
  logic [1:0]  active_app;
  logic [3:0]  app_enable;
  logic        in_menu;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        in_menu;
    logic [1:0]  cursor;
    logic [3:0]  en;
    logic [15:0] oled;
    logic [3:0]  an;
    logic [7:0]  seg;
  } exp_t;

  exp_t sb[$];

  app_display_arbiter #(
    .N_APPS       (4),
    .IDX_W        (2),
    .BLANK_FRAMES (2),
    .BLANK_COLOUR (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_select  (btn_select),
    .force_exit  (force_exit),
    .app_ended   (app_ended),
    .menu_oled   (menu_oled),
    .app_oled    (app_oled),
    .app_an      (app_an),
    .app_seg     (app_seg),
    .oled_data   (oled_data),
    .an          (an),
    .seg         (seg),
    .cursor      (cursor),
    .active_app  (active_app),
    .app_enable  (app_enable),
    .in_menu     (in_menu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic im, input logic [1:0] cur, input logic [3:0] en,
                          input logic [15:0] oled, input logic [3:0] a, input logic [7:0] s);
    exp_t e;
    e.in_menu = im; e.cursor = cur; e.en = en; e.oled = oled; e.an = a; e.seg = s;
    sb.push_back(e);
  endtask

  // Drive one cycle of pulses, then pop the expected snapshot and compare 1 time unit after the edge.
  task automatic step(input string tag, input logic fb, input logic up, input logic dn,
                      input logic sel, input logic fx, input logic [3:0] ended);
    exp_t e;
    frame_begin = fb; btn_up = up; btn_down = dn; btn_select = sel;
    force_exit = fx; app_ended = ended;
    @(posedge clk);
    #1;
    frame_begin = 0; btn_up = 0; btn_down = 0; btn_select = 0; force_exit = 0; app_ended = '0;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_in_menu"}, 16'(in_menu), 16'(e.in_menu));
      chk({tag, "_cursor"},  16'(cursor),  16'(e.cursor));
      chk({tag, "_enable"},  16'(app_enable), 16'(e.en));
      chk({tag, "_oled"},    oled_data,   e.oled);
      chk({tag, "_an"},      16'(an),     16'(e.an));
      chk({tag, "_seg"},     16'(seg),    16'(e.seg));
    end
  endtask

  initial begin
    reset = 1; frame_begin = 0; btn_up = 0; btn_down = 0; btn_select = 0;
    force_exit = 0; app_ended = '0;
    menu_oled = 16'h1234;
    app_oled  = {16'h07E0, 16'hF800, 16'h001F, 16'hAAAA};
    app_an    = {4'h7, 4'hB, 4'hD, 4'hE};
    app_seg   = {8'hC0, 8'hA4, 8'hF9, 8'h92};

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 0, 4'b0000, 16'h0000, 4'hF, 8'hFF);
      step("reset", 0, 0, 0, 0, 0, 4'b0000);
    end
    reset = 0;
    push_exp(1, 0, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("menu_idle", 0, 0, 0, 0, 0, 4'b0000);

    // Cursor wrap and simultaneous buttons
    push_exp(1, 3, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("up_wrap",   0, 1, 0, 0, 0, 4'b0000);
    push_exp(1, 0, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("down_wrap", 0, 0, 1, 0, 0, 4'b0000);
    push_exp(1, 0, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("up_down",   0, 1, 1, 0, 0, 4'b0000);
    push_exp(1, 1, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("down1",     0, 0, 1, 0, 0, 4'b0000);
    push_exp(1, 2, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("down2",     0, 0, 1, 0, 0, 4'b0000);

    // Launch app 2 with two blank frames; buttons ignored while blanking
    push_exp(0, 2, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("sel2",      0, 0, 0, 1, 0, 4'b0000);
    push_exp(0, 2, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("enter_btn", 0, 0, 1, 0, 0, 4'b0000);
    push_exp(0, 2, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("enter_fb1", 1, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 2, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("enter_gap", 0, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 2, 4'b0100, 16'h0000, 4'hF, 8'hFF); step("enter_fb2", 1, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 2, 4'b0100, 16'hF800, 4'hB, 8'hA4); step("run2",      0, 0, 0, 0, 0, 4'b0000);

    // Foreign app_ended ignored, own app_ended exits
    push_exp(0, 2, 4'b0100, 16'hF800, 4'hB, 8'hA4); step("other_end", 0, 1, 0, 0, 0, 4'b0010);
    push_exp(0, 2, 4'b0000, 16'hF800, 4'hB, 8'hA4); step("own_end",   0, 0, 0, 0, 0, 4'b0100);
    push_exp(0, 2, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("exit_idle", 0, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 2, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("exit_fb1",  1, 0, 0, 0, 0, 4'b0000);
    push_exp(1, 2, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("exit_fb2",  1, 0, 0, 0, 0, 4'b0000);
    push_exp(1, 2, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("back_menu", 0, 0, 0, 0, 0, 4'b0000);

    // Launch app 1, leave via force_exit
    push_exp(1, 1, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("up_to1",    0, 1, 0, 0, 0, 4'b0000);
    push_exp(0, 1, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("sel1",      0, 0, 0, 1, 0, 4'b0000);
    push_exp(0, 1, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("e1_fb1",    1, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 1, 4'b0010, 16'h0000, 4'hF, 8'hFF); step("e1_fb2",    1, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 1, 4'b0010, 16'h001F, 4'hD, 8'hF9); step("run1",      0, 0, 0, 0, 0, 4'b0000);
    push_exp(0, 1, 4'b0000, 16'h001F, 4'hD, 8'hF9); step("force",     0, 0, 0, 0, 1, 4'b0000);
    push_exp(0, 1, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("x1_fb1",    1, 0, 0, 0, 0, 4'b0000);
    push_exp(1, 1, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("x1_fb2",    1, 0, 0, 0, 0, 4'b0000);
    push_exp(1, 1, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("menu1",     0, 0, 0, 0, 0, 4'b0000);

    // Reset during S_ENTER after one frame returns straight to the menu
    push_exp(0, 1, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("sel_r",     0, 0, 0, 1, 0, 4'b0000);
    push_exp(0, 1, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("r_fb1",     1, 0, 0, 0, 0, 4'b0000);
    reset = 1;
    push_exp(1, 0, 4'b0000, 16'h0000, 4'hF, 8'hFF); step("mid_reset", 0, 0, 0, 0, 0, 4'b0000);
    reset = 0;
    push_exp(1, 0, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("post_r1",   1, 0, 0, 0, 0, 4'b0000);
    push_exp(1, 0, 4'b0000, 16'h1234, 4'hF, 8'hFF); step("post_r2",   1, 0, 0, 0, 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
